// File: rtl/hazard_pkg.sv
// Shared constants and types for the IF/X/M-WB hazard and forwarding scheduler.
`timescale 1ns/1ps
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_AGE1 = 2'd1;
  localparam logic [1:0] FWD_AGE2 = 2'd2;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_LDUSE = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } age1_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } age2_t;

  // The youngest producer always wins over the older one.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input age1_t a1, input age2_t a2);
    if (a1.valid && a1.rd == rs)      return FWD_AGE1;
    else if (a2.valid && a2.rd == rs) return FWD_AGE2;
    else                              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_reg_use_decode.sv
// Register-usage decode of one 32-bit instruction: destination, sources and
// which of them the instruction actually writes or reads.
`timescale 1ns/1ps
module reg_use_decode
  import hazard_pkg::*;
(
  input  logic [31:0]      inst_i,
  output logic [REG_W-1:0] rd_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o,
  output logic             writer_o,
  output logic             is_load_o,
  output logic             uses_rs1_o,
  output logic             uses_rs2_o
);

  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = inst_i[6:0];
  assign rd_o        = inst_i[11:7];
  assign rs1_o       = inst_i[19:15];
  assign rs2_o       = inst_i[24:20];
  assign unused_bits = ^{inst_i[31:25], inst_i[14:12]};

  assign writer_o   = (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd_o != '0);
  assign is_load_o  = (opc == OPC_LOAD);
  assign uses_rs1_o = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
  assign uses_rs2_o = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding-select, load-use bubble and memory-freeze control for the X stage,
// with a saturating stall-cycle counter.
`timescale 1ns/1ps
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            x_inst,
  input  logic                   x_valid,
  input  logic                   flush,
  input  logic                   dmem_stall,
  input  logic                   cnt_clear,
  output logic [1:0]             fwd_sel_rs1,
  output logic [1:0]             fwd_sel_rs2,
  output logic                   stall,
  output logic                   x_fire,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [REG_W-1:0] rd, rs1, rs2;
  logic             writer, is_load, uses_rs1, uses_rs2;

  reg_use_decode u_dec (
    .inst_i     (x_inst),
    .rd_o       (rd),
    .rs1_o      (rs1),
    .rs2_o      (rs2),
    .writer_o   (writer),
    .is_load_o  (is_load),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  age1_t                  age1_q, age1_d;
  age2_t                  age2_q, age2_d;
  logic [0:0]             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   load_use;

  assign load_use = x_valid & ~flush & age1_q.valid & age1_q.is_load &
                    ((uses_rs1 & (rs1 == age1_q.rd)) | (uses_rs2 & (rs2 == age1_q.rd)));

  assign stall        = reset_n & (dmem_stall | ((state_q == ST_RUN) & load_use));
  assign x_fire       = reset_n & x_valid & ~stall & ~flush;
  assign fwd_sel_rs1  = reset_n ? fwd_sel(rs1, age1_q, age2_q) : FWD_RF;
  assign fwd_sel_rs2  = reset_n ? fwd_sel(rs2, age1_q, age2_q) : FWD_RF;
  assign stall_cycles = cnt_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    age1_d  = age1_q;
    age2_d  = age2_q;
    state_d = state_q;
    if (!dmem_stall) begin
      age2_d.valid = age1_q.valid;
      age2_d.rd    = age1_q.rd;
      if (state_q == ST_RUN && load_use) begin
        // Bubble: the load moves to age2 so the held consumer forwards from there.
        age1_d  = '0;
        state_d = ST_LDUSE;
      end else begin
        age1_d.valid   = x_fire & writer;
        age1_d.rd      = rd;
        age1_d.is_load = is_load;
        state_d        = ST_RUN;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear)                cnt_d = '0;
    else if (stall && cnt_q != '1) cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (!reset_n) begin
      age1_q  <= '0;
      age2_q  <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      age1_q  <= age1_d;
      age2_q  <= age2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] x_inst;
  logic        x_valid, flush, dmem_stall, cnt_clear;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic        stall, x_fire;
  logic [3:0]  stall_cycles;

  hazard_ctrl #(.STALL_CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x_inst       (x_inst),
    .x_valid      (x_valid),
    .flush        (flush),
    .dmem_stall   (dmem_stall),
    .cnt_clear    (cnt_clear),
    .fwd_sel_rs1  (fwd_sel_rs1),
    .fwd_sel_rs2  (fwd_sel_rs2),
    .stall        (stall),
    .x_fire       (x_fire),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       stall;
    logic       fire;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  string      sb_name[$];
  exp_t       mon_e;
  string      mon_n;
  logic [3:0] model_cnt;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm,
                                        input logic [2:0] f3, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, rs1);
    return enc_i(rd, rs1, 12'd0, 3'b010, OP_LOAD);
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return enc_i(rd, rs1, imm, 3'b000, OP_OPIMM);
  endfunction

  // Drive one cycle and queue what the DUT must show during it.
  task automatic step(input logic [31:0] inst, input logic v, fl, ds, clr,
                      input logic [1:0] e1, e2, input logic es, ef, input string name);
    exp_t e;
    x_inst = inst; x_valid = v; flush = fl; dmem_stall = ds; cnt_clear = clr;
    e.rs1 = e1; e.rs2 = e2; e.stall = es; e.fire = ef; e.cnt = model_cnt;
    sb.push_back(e);
    sb_name.push_back(name);
    @(posedge clk);
    if (!reset_n || clr)              model_cnt = 4'd0;
    else if (es && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
    #1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "bubble");
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_n = sb_name.pop_front();
      checks++; if (fwd_sel_rs1 !== mon_e.rs1) begin errors++; $display("FAIL %s rs1_sel got %0d want %0d", mon_n, fwd_sel_rs1, mon_e.rs1); end
      checks++; if (fwd_sel_rs2 !== mon_e.rs2) begin errors++; $display("FAIL %s rs2_sel got %0d want %0d", mon_n, fwd_sel_rs2, mon_e.rs2); end
      checks++; if (stall !== mon_e.stall) begin errors++; $display("FAIL %s stall got %b want %b", mon_n, stall, mon_e.stall); end
      checks++; if (x_fire !== mon_e.fire) begin errors++; $display("FAIL %s x_fire got %b want %b", mon_n, x_fire, mon_e.fire); end
      checks++; if (stall_cycles !== mon_e.cnt) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", mon_n, stall_cycles, mon_e.cnt); end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; x_inst = lw(5'd1, 5'd1); x_valid = 1'b1; flush = 1'b0;
    dmem_stall = 1'b1; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall got %b want 0", stall); end
    checks++; if (x_fire !== 1'b0) begin errors++; $display("FAIL reset x_fire got %b want 0", x_fire); end
    checks++; if (fwd_sel_rs1 !== 2'd0) begin errors++; $display("FAIL reset rs1_sel got %0d want 0", fwd_sel_rs1); end
    checks++; if (fwd_sel_rs2 !== 2'd0) begin errors++; $display("FAIL reset rs2_sel got %0d want 0", fwd_sel_rs2); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset stall_cycles got %0d want 0", stall_cycles); end
    @(posedge clk); #1;
    reset_n = 1'b1; dmem_stall = 1'b0; x_valid = 1'b0; x_inst = 32'd0;
    model_cnt = 4'd0;
  endtask

  task automatic test_alu_fwd();
    step(addi(5'd5, 5'd0, 12'd3), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "alu_addi");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 0, 0, 0, 2'd1, 2'd1, 0, 1, "alu_add");
    step(enc_r(5'd7, 5'd6, 5'd5, 7'h20), 1, 0, 0, 0, 2'd1, 2'd2, 0, 1, "alu_sub");
    bubble(2);
  endtask

  task automatic test_load_use();
    step(lw(5'd8, 5'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "lu_lw");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd1, 2'd0, 1, 0, "lu_stall");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd2, 2'd0, 0, 1, "lu_ldfwd");
    bubble(2);
  endtask

  task automatic test_nonwriters();
    step(enc_s(5'd4, 5'd3, 12'd5), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_sw");
    step(enc_r(5'd1, 5'd5, 5'd3, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_after_sw");
    bubble(2);
    step(enc_b(5'd1, 5'd2, 13'd8), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_beq");
    step(enc_r(5'd3, 5'd8, 5'd8, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_after_beq");
    bubble(2);
    step(addi(5'd0, 5'd0, 12'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_addi_x0");
    step(enc_r(5'd1, 5'd0, 5'd0, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "nw_read_x0");
    bubble(2);
  endtask

  task automatic test_dmem_freeze();
    step(addi(5'd5, 5'd0, 12'd3), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "dm_addi");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 1, 1, 0, 2'd1, 2'd1, 1, 0, "dm_frz1");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 1, 1, 0, 2'd1, 2'd1, 1, 0, "dm_frz2");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 0, 1, 0, 2'd1, 2'd1, 1, 0, "dm_frz3");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 0, 0, 0, 2'd1, 2'd1, 0, 1, "dm_release");
    step(enc_r(5'd7, 5'd6, 5'd5, 7'h20), 1, 0, 0, 0, 2'd1, 2'd2, 0, 1, "dm_sub");
    bubble(2);
  endtask

  task automatic test_flush();
    step(addi(5'd5, 5'd0, 12'd3), 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, "fl_addi_killed");
    step(enc_r(5'd6, 5'd5, 5'd5, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "fl_reader");
    bubble(2);
    step(lw(5'd8, 5'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "fl_lw");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd1, 2'd0, 1, 0, "fl_lu_stall");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 1, 0, 0, 2'd2, 2'd0, 0, 0, "fl_in_lduse");
    step(lw(5'd8, 5'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "fl_lw2");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd1, 2'd0, 1, 0, "fl_lu_stall2");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd2, 2'd0, 0, 1, "fl_ldfwd2");
    bubble(2);
  endtask

  task automatic test_back_to_back();
    step(lw(5'd8, 5'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "b2b_lw8");
    step(lw(5'd9, 5'd8), 1, 0, 0, 0, 2'd1, 2'd0, 1, 0, "b2b_lw9_stall");
    step(lw(5'd9, 5'd8), 1, 0, 0, 0, 2'd2, 2'd0, 0, 1, "b2b_lw9_fire");
    step(enc_r(5'd10, 5'd9, 5'd9, 7'h00), 1, 0, 0, 0, 2'd1, 2'd1, 1, 0, "b2b_add_stall");
    step(enc_r(5'd10, 5'd9, 5'd9, 7'h00), 1, 0, 0, 0, 2'd2, 2'd2, 0, 1, "b2b_add_fire");
    bubble(2);
  endtask

  task automatic test_reset_mid_bubble();
    step(lw(5'd8, 5'd1), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "rmb_lw");
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd1, 2'd0, 1, 0, "rmb_stall");
    reset_n = 1'b0;
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, "rmb_in_reset");
    reset_n = 1'b1;
    step(enc_r(5'd9, 5'd8, 5'd2, 7'h00), 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, "rmb_after");
    bubble(2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) step(32'd0, 0, 0, 1, 0, 2'd0, 2'd0, 1, 0, "sat_stall");
    @(negedge clk);
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_value got %0d want 15", stall_cycles); end
    step(32'd0, 0, 0, 1, 1, 2'd0, 2'd0, 1, 0, "sat_clear");
    step(32'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, "sat_after_clear");
    @(negedge clk);
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL clr_value got %0d want 0", stall_cycles); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_cnt = 4'd0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_nonwriters();
    test_dmem_freeze();
    test_flush();
    test_back_to_back();
    test_reset_mid_bubble();
    test_saturation();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding scheduler for the three-stage (IF, X, M/WB) pipeline. Tracks the destination registers of the two most recently advanced instructions and drives the X-stage rs1/rs2 forwarding mux selects. Inserts a one-cycle bubble on load-use hazards and freezes on data-memory stalls. Counts stall cycles for performance monitoring.

## Interface

Parameters:
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `x_inst`  in  32  instruction currently in X
- `x_valid`  in  1  X holds a real instruction (0 = bubble)
- `flush`  in  1  kill the instruction in X (taken branch/jump redirect)
- `dmem_stall`  in  1  data memory not ready; whole pipeline freezes
- `cnt_clear`  in  1  synchronous clear of `stall_cycles`
- `fwd_sel_rs1`  out  2  0 = regfile, 1 = M/WB write data (age1), 2 = previous write data (age2)
- `fwd_sel_rs2`  out  2  same encoding for rs2; also feeds store data
- `stall`  out  1  hold PC and X this cycle
- `x_fire`  out  1  X instruction advances this cycle
- `stall_cycles`  out  STALL_CNT_W  saturating count of cycles with `stall`=1

## Operation

- Writer: opcode not BRANCH and not STORE, and rd != x0. Load: opcode LOAD.
- rs1 use: every opcode except LUI, AUIPC, JAL. rs2 use: R-type, STORE, BRANCH only.
- History slots:
  - age1 = {valid, rd, is_load}
  - age2 = {valid, rd}
- Forward select, per source:
  - 1 if age1.valid and age1.rd == rs.
  - Otherwise 2 if age2.valid and age2.rd == rs.
  - Otherwise 0.
  - Age1 always wins. Selects are computed from field bits regardless of use decode.
- `load_use` = x_valid & !flush & age1.valid & age1.is_load & ((uses_rs1 & rs1 == age1.rd) | (uses_rs2 & rs2 == age1.rd)).
- `stall` = reset_n & (dmem_stall | (state == RUN & load_use)).
- `x_fire` = x_valid & !stall & !flush.
- FSM states RUN and LDUSE:
  - RUN, `load_use`, !dmem_stall: shift history with a bubble (age2 <= age1; age1 <= invalid); go to LDUSE.
  - LDUSE: the load now sits in age2 and the consumer forwards with select 2. `load_use` is masked. Advance normally; return to RUN.
- Normal advance (no dmem_stall, no load-use bubble): age2 <= age1; age1 <= {x_fire & writer(x_inst), rd, is_load}.
- Flush: the killed instruction enters age1 as invalid. A flush in LDUSE returns to RUN.
- `dmem_stall`=1 freezes everything: history, state, and forwarding inputs. `flush` is ignored that cycle; upstream holds it.
- Counter:
  - Increments when `stall`=1 and saturates at all-ones.
  - `cnt_clear` has priority over increment (the result is 0).

## Timing

- Reset (reset_n=0 at a clock edge):
  - Both history slots invalid, state RUN, `stall_cycles`=0.
  - While reset_n=0: `stall`=0, `x_fire`=0, both selects 0.
- Selects, `stall` and `x_fire` are combinational from inputs plus registered history, valid in the same cycle. There are no combinational paths from outputs back to inputs.
- Load-use penalty is exactly one cycle, plus any `dmem_stall` cycles.
- `reset_n` deasserted mid-bubble discards LDUSE; the next cycle starts in RUN with empty history.
- Back-to-back loads with a chained dependency: each consumer incurs its own single bubble.

## Structure

- Shared package `hazard_pkg` holds:
  - opcode constants (reuse the `OPC_*` values)
  - forward-select encodings `FWD_RF`/`FWD_AGE1`/`FWD_AGE2`
  - FSM state encoding
  - history slot field widths
- Sub-module `reg_use_decode`: combinational decode of rd, rs1, rs2, writer, is_load, uses_rs1, uses_rs2 from a 32-bit instruction. It is instantiated for `x_inst`.

## Test plan

- **Back-to-back ALU dependency.** `addi x5,x0,3` then `add x6,x5,x5` -> on the add, `fwd_sel_rs1`=`fwd_sel_rs2`=1, no stall. A third instruction `sub x7,x6,x5` -> rs1 sel 1, rs2 sel 2.
- **Load-use bubble.** `lw x8,0(x1)` then `add x9,x8,x2`:
  - Cycle N: `stall`=1, `x_fire`=0.
  - Cycle N+1: state LDUSE, `fwd_sel_rs1`=2, `x_fire`=1, `stall_cycles`=1.
- **Non-writers and x0.**
  - `sw x3,0(x4)` followed by a reader of x0/x3 -> all selects 0.
  - `beq` followed by a reader of any register -> all selects 0.
  - `addi x0,x0,1` followed by `add x1,x0,x0` -> selects 0.
- **dmem_stall freeze.** Hold `dmem_stall`=1 for 3 cycles mid-sequence -> history and selects unchanged, `stall`=1, `stall_cycles` +3. Flush asserted in those cycles has no effect.
- **Flush.**
  - Flush on `addi x5,...` -> a following reader of x5 gets select 0.
  - Flush during LDUSE -> next state RUN.
- **Saturation and clear.** With STALL_CNT_W=4, 20 stall cycles -> `stall_cycles`=15. `cnt_clear` together with `stall` -> 0.
